// File: rtl/wb_regfile.sv
// Write-back stage of the semiMIPS pipeline: selects the write-back value and
// commits it to a 32-entry register file with two bypassed ID-stage read ports.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regwr,
  input  logic [1:0]            memtoreg,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0] aluresult,
  input  logic [DATA_WIDTH-1:0] memdata,
  input  logic [DATA_WIDTH-1:0] linkaddr,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] wbdata
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en_d;

  // NOTE: every always_comb output gets a value on every path (default first),
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    wbdata = aluresult;
    case (wb_sel_e'(memtoreg))
      WB_MEM:  wbdata = memdata;
      WB_LINK: wbdata = linkaddr;
      default: wbdata = aluresult;
    endcase
  end

  // r0 is hardwired: a write to index 0 never commits and never bypasses.
  assign wr_en_d = regwr && (wraddr != '0);

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the whole array is cleared on reset (contents must read as zero
  // afterwards), so it is built from flops rather than an unresettable RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[wraddr] <= wbdata;
    end
  end

  always_comb begin
    rs_data = '0;
    if (rst || rs_addr == '0) begin
      rs_data = '0;
    end else if (wr_en_d && wraddr == rs_addr) begin
      rs_data = wbdata;
    end else begin
      rs_data = regs_q[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rst || rt_addr == '0) begin
      rt_data = '0;
    end else if (wr_en_d && wraddr == rt_addr) begin
      rt_data = wbdata;
    end else begin
      rt_data = regs_q[rt_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued as stimulus is
// driven and compared against the DUT outputs mid-cycle.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwr;
  logic [1:0]    memtoreg;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] aluresult;
  logic [DW-1:0] memdata;
  logic [DW-1:0] linkaddr;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] wbdata;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .regwr    (regwr),
    .memtoreg (memtoreg),
    .wraddr   (wraddr),
    .aluresult(aluresult),
    .memdata  (memdata),
    .linkaddr (linkaddr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wbdata   (wbdata)
  );

  typedef enum int {P_RS, P_RT, P_WB} port_e;
  typedef struct {
    string         tag;
    port_e         port;
    logic [DW-1:0] exp;
  } sb_item_t;

  sb_item_t      sb_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] model [32];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_mux(input logic [1:0] sel, input logic [DW-1:0] alu,
                                            input logic [DW-1:0] mem, input logic [DW-1:0] link);
    case (sel)
      2'b01:   return mem;
      2'b10:   return link;
      default: return alu;
    endcase
  endfunction

  task automatic push(input string tag, input port_e p, input logic [DW-1:0] e);
    sb_item_t it;
    it.tag  = tag;
    it.port = p;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  task automatic sample();
    sb_item_t it;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.port)
        P_RS:    check(it.tag, rs_data, it.exp);
        P_RT:    check(it.tag, rt_data, it.exp);
        default: check(it.tag, wbdata, it.exp);
      endcase
    end
  endtask

  // Advance one edge; the reference array commits from the driven inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (regwr && wraddr != '0) begin
      model[wraddr] = ref_mux(memtoreg, aluresult, memdata, linkaddr);
    end
    #1;
  endtask

  task automatic drive(input logic wr, input logic [1:0] sel, input logic [AW-1:0] wa,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic [DW-1:0] link);
    regwr     = wr;
    memtoreg  = sel;
    wraddr    = wa;
    aluresult = alu;
    memdata   = mem;
    linkaddr  = link;
  endtask

  // Read both ports from the stored array (caller keeps regwr low).
  task automatic expect_read(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    rs_addr = a;
    rt_addr = b;
    push($sformatf("%s_rs_r%0d", tag, a), P_RS, (a == 0) ? '0 : model[a]);
    push($sformatf("%s_rt_r%0d", tag, b), P_RT, (b == 0) ? '0 : model[b]);
    sample();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    rs_addr = '0;
    rt_addr = '0;
    tick();
    tick();

    // While in reset the read ports are forced low even with a live write.
    drive(1'b1, 2'b10, 5'd3, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
    rs_addr = 5'd3;
    rt_addr = 5'd7;
    push("rst_force_rs", P_RS, '0);
    push("rst_force_rt", P_RT, '0);
    push("rst_wb_mux", P_WB, 32'h3333_0000);
    sample();
    tick();
    rst = 1'b0;

    // Fill every register with random data through random mux selects.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), AW'(i), $urandom, $urandom, $urandom);
      tick();
    end
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    for (int i = 1; i < 32; i += 6) expect_read("fill", AW'(i), AW'(32 - i));

    // Reset pulse wins over a simultaneous write to r3.
    rst = 1'b1;
    drive(1'b1, 2'b00, 5'd3, 32'hAAAA_AAAA, '0, '0);
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    push("rstwr_rs", P_RS, '0);
    push("rstwr_rt", P_RT, '0);
    push("rstwr_wb", P_WB, 32'hAAAA_AAAA);
    sample();
    tick();
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    for (int i = 1; i < 32; i++) begin
      rs_addr = AW'(i);
      rt_addr = AW'(32 - i);
      push($sformatf("post_rst_rs_r%0d", i), P_RS, '0);
      push($sformatf("post_rst_rt_r%0d", 32 - i), P_RT, '0);
      sample();
    end

    // Write-back mux: each source committed to its own register.
    drive(1'b1, 2'b00, 5'd5, 32'h1234_5678, 32'h0BAD_0000, 32'h0BAD_0001);
    push("mux00_wb", P_WB, 32'h1234_5678);
    sample();
    tick();
    drive(1'b1, 2'b01, 5'd6, 32'h0BAD_0002, 32'hDEAD_BEEF, 32'h0BAD_0003);
    push("mux01_wb", P_WB, 32'hDEAD_BEEF);
    sample();
    tick();
    drive(1'b1, 2'b10, 5'd31, 32'h0BAD_0004, 32'h0BAD_0005, 32'h0040_0008);
    push("mux10_wb", P_WB, 32'h0040_0008);
    sample();
    tick();
    drive(1'b1, 2'b11, 5'd10, 32'h7777_0003, 32'h0BAD_0006, 32'h0BAD_0007);
    push("mux11_wb", P_WB, 32'h7777_0003);
    sample();
    tick();
    drive(1'b1, 2'b00, 5'd4, 32'h0000_0044, '0, '0);
    tick();
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    rs_addr = 5'd5;
    rt_addr = 5'd6;
    push("rd_r5", P_RS, 32'h1234_5678);
    push("rd_r6", P_RT, 32'hDEAD_BEEF);
    sample();
    rs_addr = 5'd31;
    rt_addr = 5'd10;
    push("rd_r31", P_RS, 32'h0040_0008);
    push("rd_r10", P_RT, 32'h7777_0003);
    sample();

    // Same-cycle bypass, then the committed value through the array.
    drive(1'b1, 2'b00, 5'd9, 32'hCAFE_0001, '0, '0);
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    push("bypass_rs", P_RS, 32'hCAFE_0001);
    push("bypass_rt", P_RT, 32'hCAFE_0001);
    sample();
    tick();
    drive(1'b0, 2'b00, 5'd9, 32'h0BAD_0009, '0, '0);
    push("bypass_held_rs", P_RS, 32'hCAFE_0001);
    push("bypass_held_rt", P_RT, 32'hCAFE_0001);
    sample();

    // Writes to r0 are discarded and never bypassed.
    drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, '0, '0);
    rs_addr = 5'd0;
    rt_addr = 5'd5;
    push("r0_same_cycle", P_RS, '0);
    push("r0_other_reg", P_RT, 32'h1234_5678);
    sample();
    tick();
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    push("r0_after_rs", P_RS, '0);
    push("r0_after_rt", P_RT, '0);
    sample();
    for (int i = 1; i < 32; i += 2) expect_read("r0_nochange", AW'(i), AW'(i + 1));

    // Disabled write leaves r4 alone; back-to-back writes to r7, last wins.
    drive(1'b0, 2'b00, 5'd4, 32'h0000_0055, '0, '0);
    rs_addr = 5'd4;
    rt_addr = 5'd4;
    push("nowr_same_cycle", P_RS, 32'h0000_0044);
    sample();
    tick();
    push("nowr_after", P_RT, 32'h0000_0044);
    sample();
    drive(1'b1, 2'b00, 5'd7, 32'h0000_0011, '0, '0);
    tick();
    drive(1'b1, 2'b01, 5'd7, 32'h0BAD_000A, 32'h0000_0022, '0);
    rs_addr = 5'd7;
    rt_addr = 5'd9;
    push("b2b_bypass", P_RS, 32'h0000_0022);
    push("b2b_other", P_RT, 32'hCAFE_0001);
    sample();
    tick();
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    push("b2b_last_wins", P_RS, 32'h0000_0022);
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer and register file of the semiMIPS pipeline.
- Takes the WB-stage control outputs (memtoreg[1:0], regwr) and the WB-stage data.
- Selects the write-back value and commits it to a 32-entry register file.
- Serves the two ID-stage read ports, with same-cycle write-through bypass so the ID stage always sees the value being written back.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- regwr  input  1  write enable from WB pipeline register
- memtoreg  input  2  write-back source select from WB pipeline register
- wraddr  input  ADDR_WIDTH  destination register index
- aluresult  input  DATA_WIDTH  ALU result carried to WB
- memdata  input  DATA_WIDTH  data-memory load result carried to WB
- linkaddr  input  DATA_WIDTH  return address (PC+8) for jal/jalr
- rs_addr  input  ADDR_WIDTH  read port A index (ID stage)
- rt_addr  input  ADDR_WIDTH  read port B index (ID stage)
- rs_data  output  DATA_WIDTH  read port A data
- rt_data  output  DATA_WIDTH  read port B data
- wbdata  output  DATA_WIDTH  selected write-back value (forwarding unit tap)

Behaviour:
- Clock/reset: clock is clk; reset is rst, synchronous and active-high.

Write-back mux (combinational), wbdata:
- memtoreg = 00: aluresult
- memtoreg = 01: memdata
- memtoreg = 10: linkaddr
- memtoreg = 11: reserved; selects aluresult
- wbdata is driven regardless of regwr.

Write:
- On posedge clk with rst=0, regwr=1 and wraddr!=0: reg[wraddr] <= wbdata.
- Writes to index 0 are discarded; reg[0] reads 0 at all times.
- regwr=0: no state change.

Reset:
- On posedge clk with rst=1, every register clears to 0. This takes priority over a simultaneous write: the write is dropped.
- While rst=1, rs_data and rt_data are forced to 0. wbdata still follows the mux.
- Reset asserted mid-stream: the register contents after the edge are all zero, independent of pending WB control values.

Read (combinational, zero latency):
- Address 0 returns 0.
- Otherwise, if regwr=1 and wraddr equals the read address (nonzero), return wbdata (write-through bypass).
- Otherwise return reg[addr].
- Both ports are independent; rs_addr == rt_addr is legal and both ports return identical data.

Simultaneous events:
- A write and a read of the same index in the same cycle: the read returns the new value (bypass). After the edge, the stored value equals it.
- Back-to-back writes to the same index: the last one wins.

Widths:
- No arithmetic; all data paths are DATA_WIDTH bits.
- No sign or zero extension is performed here.

Outputs after reset:
- rs_data = 0, rt_data = 0 for any address.
- wbdata = mux result of current inputs.

State:
- The register array is the only state; there is no FSM.
- Latency: write visible through the array one edge after commit, and visible in the same cycle via bypass.

Test Plan:
- Reset: pulse rst for 1 cycle after random writes -> every index 1..31 reads 0 on both ports; while rst=1, rs_data = rt_data = 0 even with regwr=1.
- Mux/write: memtoreg=00, aluresult=0x1234_5678, wraddr=5, regwr=1; next cycle memtoreg=01, memdata=0xDEAD_BEEF, wraddr=6; then memtoreg=10, linkaddr=0x0040_0008, wraddr=31 -> reads of r5, r6, r31 return those values; memtoreg=11 writes aluresult.
- Bypass: same cycle regwr=1, wraddr=9, aluresult=0xCAFE_0001, rs_addr=rt_addr=9 -> rs_data = rt_data = 0xCAFE_0001 before the edge; after the edge with regwr=0 the value is still read.
- Register zero: regwr=1, wraddr=0, aluresult=0xFFFF_FFFF -> rs_addr=0 reads 0 both in the same cycle and after the edge; no other register changes.
- Reset vs write: rst=1 and regwr=1, wraddr=3, aluresult=0xAAAA_AAAA in the same cycle -> after the edge, with rst=0, r3 reads 0.
- Disabled write and last-wins: regwr=0 with wraddr=4, aluresult=0x55 -> r4 unchanged; consecutive writes 0x11 then 0x22 to r7 -> r7 reads 0x22.
